vml_fetch: RTL and testbench
============================

# vml_fetch

Video-matrix line stage downstream of the matrix counter block. It consumes `vc`, `rc` and `idle`, and generates the 14-bit c-access address on badlines. It captures the 12-bit c-access data (8-bit char plus 4-bit color) into a 40-entry line buffer, then replays that buffer for every g-access of the following lines. Per g-access it outputs the character code, the color and the 14-bit g-access address to the pixel sequencer and the address mux.

## Interface
- No parameters.
- `clk_dot4x`  in  1  sole clock; all state on its rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `clk_phi`  in  1  phi level; 0 = first half of cycle (g-access), 1 = second half (c-access).
- `phi_phase_start_1`  in  1  one-clock strobe, phase slot 1 of each phi half.
- `phi_phase_start_dav`  in  1  one-clock strobe, data-valid slot of each phi half; `dbi` is stable here.
- `cycle_num`  in  7  raster cycle, stable across both phi halves of a cycle.
- `badline`  in  1  badline condition for the current line.
- `idle`  in  1  idle state from the matrix stage.
- `vc`  in  10  video counter.
- `rc`  in  3  row counter.
- `vm`  in  4  video-matrix base (register 0x18 bits 7:4).
- `cb`  in  3  char/bitmap base (register 0x18 bits 3:1).
- `bmm`, `ecm`  in  1 each  bitmap mode and extended color mode.
- `dbi`  in  12  data bus in; 11:8 color, 7:0 char.
- `c_addr`  out  14  c-access address.
- `g_addr`  out  14  g-access address.
- `char_out`  out  8  character code for the current g-access.
- `color_out`  out  4  color nibble for the current g-access.
- `g_strobe`  out  1  one-clock pulse when `char_out`, `color_out` and `g_addr` update.
- `vmli`  out  6  line-buffer index, for debug.

## Operation
- Line buffer: 40 x 12 bits, no reset. Contents persist across non-badlines, so one badline fetch serves 8 rows.
- **vmli clear:** at `clk_phi=1` and `phi_phase_start_1` with `cycle_num==14`, `vmli` <= 0.
- **c-address:** at `clk_phi=1` and `phi_phase_start_1` with `cycle_num` in 15..54, `c_addr` <= {vm, vc}.
- **c-capture:** at `clk_phi=1` and `phi_phase_start_dav`, with `cycle_num` in 15..54, `badline=1` and `vmli<40`, write buf[vmli] <= `dbi`.
- **g-access:** at `clk_phi=0` and `phi_phase_start_1`, with `cycle_num` in 16..55 and `vmli<40`:
  - pulse `g_strobe` for one clock;
  - `vmli` <= `vmli`+1;
  - outputs are computed from the pre-increment `vmli`, as below.
- **Outputs when `idle=0`:**
  - `char_out` <= buf[vmli][7:0], `color_out` <= buf[vmli][11:8].
  - Text mode (`bmm=0`): `g_addr` = {cb, char, rc}.
  - Bitmap mode (`bmm=1`): `g_addr` = {cb[2], vc, rc}.
  - If `ecm=1`, force bits 10:9 of `g_addr` to 0.
- **Outputs when `idle=1`:**
  - `char_out` <= 0, `color_out` <= 0.
  - `g_addr` = `ecm` ? 14'h39ff : 14'h3fff.
  - `vmli` still increments.
- **Saturation:** `vmli` stops at 40. No read or write occurs with `vmli==40`.
- **Priority:** clear and increment can never coincide (different cycles and phi halves). A write and a read in the same half cannot occur.

## Timing
- All outputs are registered.
- **Latency:**
  - The char written in cycle N (c-capture) is presented at the g-access strobe of cycle N+1. That is one phi half later.
  - `g_addr` is valid from the clock after `g_strobe` through the rest of the phi-low half.
- **Reset values:** `vmli`=0, `c_addr`=0, `g_addr`=14'h3fff, `char_out`=0, `color_out`=0, `g_strobe`=0.
- **Reset mid-line:**
  - Outputs return to reset values immediately.
  - The buffer retains its contents.
  - Capture resumes only from the next cycle-14 clear onward. Before that, writes go to the index held in `vmli`.
- **`badline` deasserted mid-fetch:** capture stops from that cycle. Higher entries keep the previous line's data.
- `vc` and `rc` are sampled at the g-access strobe and are not held internally.

## Test plan
- **Badline capture/replay:**
  - Stimulus: badline line; `dbi` = {i[3:0], 8'h40+i} in cycle 15+i.
  - Required: `g_strobe` in cycles 16..55, `char_out`=8'h40+i, `color_out`=i[3:0]; text `g_addr` = {cb, char, rc}.
- **Non-badline reuse:** next line with `badline=0` and different `dbi` -> same 40 chars replayed; buffer unmodified; `vmli` ends at 40.
- **Idle:**
  - With `idle=1`, `ecm=0` -> `g_addr`=14'h3fff and `char_out`=0.
  - With `ecm=1` -> `g_addr`=14'h39ff.
- **Modes:** with `bmm=1`, `vc`=10'h155, `rc`=5, `cb`=3'b100 -> `g_addr`=14'h2aad. With `ecm=1` and char 8'hff in text mode -> `g_addr` bits 10:9 = 0.
- **Reset mid-line:** assert `rst_n`=0 at cycle 30 -> all outputs at reset values within the same clock; no `g_strobe` until the next line's cycle 16.
- **Partial badline:** drop `badline` at cycle 35 -> entries 0..19 hold the new data and entries 20..39 hold the old data on replay.

Source files
------------

// File: rtl/vml_fetch_if.sv
// Video-matrix line stage bus: timing strobes, counters and
// mode bits in; c/g-access addresses and char/color out.
interface vml_fetch_if;
    logic        clk_phi;
    logic        phi_phase_start_1;
    logic        phi_phase_start_dav;
    logic [6:0]  cycle_num;
    logic        badline;
    logic        idle;
    logic [9:0]  vc;
    logic [2:0]  rc;
    logic [3:0]  vm;
    logic [2:0]  cb;
    logic        bmm;
    logic        ecm;
    logic [11:0] dbi;
    logic [13:0] c_addr;
    logic [13:0] g_addr;
    logic [7:0]  char_out;
    logic [3:0]  color_out;
    logic        g_strobe;
    logic [5:0]  vmli;

    modport slave (
        input  clk_phi, phi_phase_start_1, phi_phase_start_dav,
        input  cycle_num, badline, idle, vc, rc, vm, cb,
        input  bmm, ecm, dbi,
        output c_addr, g_addr, char_out, color_out,
        output g_strobe, vmli
    );

    modport master (
        output clk_phi, phi_phase_start_1, phi_phase_start_dav,
        output cycle_num, badline, idle, vc, rc, vm, cb,
        output bmm, ecm, dbi,
        input  c_addr, g_addr, char_out, color_out,
        input  g_strobe, vmli
    );
endinterface

// File: rtl/vml_fetch.sv
// Video-matrix line stage: c-access capture into a 40-entry
// line buffer and per-g-access replay of char/color/address.
module vml_fetch (
    input  logic        clk_dot4x,
    input  logic        rst_n,
    vml_fetch_if.slave  bus
);
    logic [11:0] r_buf [0:39];
    logic [5:0]  r_vmli;
    logic [13:0] r_c_addr;
    logic [13:0] r_g_addr;
    logic [7:0]  r_char;
    logic [3:0]  r_color;
    logic        r_g_strobe;

    logic        w_c_win;
    logic        w_g_win;
    logic        w_room;
    logic        w_clr;
    logic        w_c_ld;
    logic        w_wr;
    logic        w_rd;
    logic [11:0] w_rd_data;
    logic [7:0]  w_char;
    logic [3:0]  w_color;
    logic [13:0] w_g_addr;

    assign w_c_win = (bus.cycle_num >= 7'd15) &&
                     (bus.cycle_num <= 7'd54);
    assign w_g_win = (bus.cycle_num >= 7'd16) &&
                     (bus.cycle_num <= 7'd55);
    assign w_room  = r_vmli < 6'd40;

    assign w_clr  = bus.clk_phi && bus.phi_phase_start_1 &&
                    (bus.cycle_num == 7'd14);
    assign w_c_ld = bus.clk_phi && bus.phi_phase_start_1 &&
                    w_c_win;
    assign w_wr   = bus.clk_phi && bus.phi_phase_start_dav &&
                    w_c_win && bus.badline && w_room;
    assign w_rd   = !bus.clk_phi && bus.phi_phase_start_1 &&
                    w_g_win && w_room;

    assign w_rd_data = r_buf[r_vmli];

    // g-access char/color/address from the pre-increment index
    always_comb begin
        w_char   = 8'h00;
        w_color  = 4'h0;
        w_g_addr = 14'h3fff;
        if (bus.idle) begin
            w_g_addr = bus.ecm ? 14'h39ff : 14'h3fff;
        end else begin
            w_char  = w_rd_data[7:0];
            w_color = w_rd_data[11:8];
            if (bus.bmm)
                w_g_addr = {bus.cb[2], bus.vc, bus.rc};
            else
                w_g_addr = {bus.cb, w_rd_data[7:0], bus.rc};
            if (bus.ecm)
                w_g_addr[10:9] = 2'b00;
        end
    end

    // Line buffer has no reset so a badline fetch survives reset
    always_ff @(posedge clk_dot4x) begin
        if (w_wr)
            r_buf[r_vmli] <= bus.dbi;
    end

    // Index, c-address and registered g-access outputs
    always_ff @(posedge clk_dot4x or negedge rst_n) begin
        if (!rst_n) begin
            r_vmli     <= 6'd0;
            r_c_addr   <= 14'd0;
            r_g_addr   <= 14'h3fff;
            r_char     <= 8'h00;
            r_color    <= 4'h0;
            r_g_strobe <= 1'b0;
        end else begin
            r_g_strobe <= w_rd;
            if (w_clr)
                r_vmli <= 6'd0;
            else if (w_rd)
                r_vmli <= r_vmli + 6'd1;
            if (w_c_ld)
                r_c_addr <= {bus.vm, bus.vc};
            if (w_rd) begin
                r_char   <= w_char;
                r_color  <= w_color;
                r_g_addr <= w_g_addr;
            end
        end
    end

    assign bus.c_addr    = r_c_addr;
    assign bus.g_addr    = r_g_addr;
    assign bus.char_out  = r_char;
    assign bus.color_out = r_color;
    assign bus.g_strobe  = r_g_strobe;
    assign bus.vmli      = r_vmli;
endmodule

// File: tb/tb_vml_fetch.sv
// Self-checking bench for vml_fetch: full raster lines driven
// against a line-level reference model plus a mode table.
module tb_vml_fetch;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    vml_fetch_if bus_if ();

    vml_fetch dut (
        .clk_dot4x (clk),
        .rst_n     (rst_n),
        .bus       (bus_if)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // line settings
    logic       s_idle, s_bmm, s_ecm;
    logic [2:0] s_cb;
    logic [3:0] s_vm;
    int         s_dbi_mode;
    bit         s_fixed;
    logic [9:0] s_fvc;
    logic [2:0] s_frc;

    // reference model state
    logic [11:0] mbuf [40];
    int          mv;
    logic [13:0] mc, mg;
    logic [7:0]  mch;
    logic [3:0]  mcol;

    // per-line results
    logic [7:0]  got_ch [40];
    logic [3:0]  got_col [40];
    logic [13:0] got_g [40];
    logic [11:0] rec_dbi [40];
    int          n_strobe;
    int          n_strobe_post_rst;

    typedef struct {
        logic        idle;
        logic        bmm;
        logic        ecm;
        logic [2:0]  cb;
        logic [9:0]  vc;
        logic [2:0]  rc;
        logic [13:0] exp_g;
        logic [7:0]  exp_ch;
        logic [3:0]  exp_col;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string name, input int act,
                       input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h",
                     name, act, exp);
        end
    endtask

    task automatic model_reset();
        mv   = 0;
        mc   = 14'd0;
        mg   = 14'h3fff;
        mch  = 8'h00;
        mcol = 4'h0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_vmli"}, int'(bus_if.vmli), 0);
        chk({tag, "_c_addr"}, int'(bus_if.c_addr), 0);
        chk({tag, "_g_addr"}, int'(bus_if.g_addr), 'h3fff);
        chk({tag, "_char"}, int'(bus_if.char_out), 0);
        chk({tag, "_color"}, int'(bus_if.color_out), 0);
        chk({tag, "_strobe"}, int'(bus_if.g_strobe), 0);
    endtask

    task automatic run_line(input bit bl, input int drop,
                            input int rst_at);
        bit in_rst = 0;
        n_strobe = 0;
        n_strobe_post_rst = 0;
        for (int cn = 0; cn < 63; cn++) begin
            if (s_fixed) begin
                bus_if.vc = s_fvc;
                bus_if.rc = s_frc;
            end else begin
                bus_if.vc = 10'($urandom_range(0, 1023));
                bus_if.rc = 3'($urandom_range(0, 7));
            end
            if (s_dbi_mode == 0 && cn >= 15 && cn <= 54)
                bus_if.dbi = {4'(cn - 15), 8'(64 + cn - 15)};
            else if (s_dbi_mode == 2)
                bus_if.dbi = 12'haff;
            else
                bus_if.dbi = 12'($urandom_range(0, 4095));
            bus_if.cycle_num = 7'(cn);
            bus_if.badline = bl && (cn < drop);
            for (int h = 0; h < 2; h++) begin
                for (int s = 0; s < 4; s++) begin
                    bit exps;
                    bit ps1;
                    bit dav;
                    int idx;
                    if (cn == rst_at && h == 0 && s == 0) begin
                        rst_n = 1'b0;
                        in_rst = 1;
                        model_reset();
                        #1;
                        chk_reset_vals("midrst");
                    end
                    if (in_rst && cn == 60 && h == 0 && s == 0) begin
                        rst_n = 1'b1;
                        in_rst = 0;
                    end
                    ps1 = (s == 1);
                    dav = (s == 3);
                    bus_if.clk_phi = h[0];
                    bus_if.phi_phase_start_1 = ps1;
                    bus_if.phi_phase_start_dav = dav;
                    exps = 0;
                    idx = mv;
                    if (!in_rst) begin
                        if (h == 1 && ps1 && cn == 14)
                            mv = 0;
                        if (h == 1 && ps1 && cn >= 15 && cn <= 54)
                            mc = 14'((int'(s_vm) << 10)
                                     + int'(bus_if.vc));
                        if (h == 1 && dav && cn >= 15 && cn <= 54
                            && bus_if.badline && mv < 40) begin
                            mbuf[mv] = bus_if.dbi;
                            rec_dbi[mv] = bus_if.dbi;
                        end
                        if (h == 0 && ps1 && cn >= 16 && cn <= 55
                            && mv < 40) begin
                            exps = 1;
                            idx = mv;
                            if (s_idle) begin
                                mch = 0;
                                mcol = 0;
                                mg = s_ecm ? 14'h39ff : 14'h3fff;
                            end else begin
                                int g;
                                mch = mbuf[mv][7:0];
                                mcol = mbuf[mv][11:8];
                                if (s_bmm)
                                    g = (int'(s_cb) / 4) * 8192
                                      + int'(bus_if.vc) * 8
                                      + int'(bus_if.rc);
                                else
                                    g = int'(s_cb) * 2048
                                      + int'(mch) * 8
                                      + int'(bus_if.rc);
                                if (s_ecm)
                                    g = g & ~32'h600;
                                mg = 14'(g);
                            end
                            mv = mv + 1;
                        end
                    end
                    @(posedge clk);
                    #1;
                    chk("g_strobe", int'(bus_if.g_strobe),
                        int'(exps));
                    chk("vmli", int'(bus_if.vmli), mv);
                    chk("c_addr", int'(bus_if.c_addr), int'(mc));
                    chk("g_addr", int'(bus_if.g_addr), int'(mg));
                    chk("char_out", int'(bus_if.char_out),
                        int'(mch));
                    chk("color_out", int'(bus_if.color_out),
                        int'(mcol));
                    if (bus_if.g_strobe) begin
                        if (idx < 40) begin
                            got_ch[idx] = bus_if.char_out;
                            got_col[idx] = bus_if.color_out;
                            got_g[idx] = bus_if.g_addr;
                        end
                        n_strobe++;
                        if (rst_at >= 0 && cn >= rst_at)
                            n_strobe_post_rst++;
                    end
                end
            end
        end
    endtask

    initial begin
        tbl[0] = '{1'b0, 1'b0, 1'b0, 3'd3, 10'h000, 3'd2,
                   14'h1ffa, 8'hff, 4'ha};
        tbl[1] = '{1'b0, 1'b0, 1'b1, 3'd3, 10'h000, 3'd2,
                   14'h19fa, 8'hff, 4'ha};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 3'd4, 10'h155, 3'd5,
                   14'h2aad, 8'hff, 4'ha};
        tbl[3] = '{1'b0, 1'b1, 1'b1, 3'd4, 10'h155, 3'd5,
                   14'h28ad, 8'hff, 4'ha};
        tbl[4] = '{1'b1, 1'b0, 1'b0, 3'd3, 10'h0aa, 3'd1,
                   14'h3fff, 8'h00, 4'h0};
        tbl[5] = '{1'b1, 1'b1, 1'b1, 3'd4, 10'h155, 3'd5,
                   14'h39ff, 8'h00, 4'h0};

        s_idle = 0; s_bmm = 0; s_ecm = 0;
        s_cb = 3'b010; s_vm = 4'h5;
        s_dbi_mode = 0; s_fixed = 0;
        s_fvc = '0; s_frc = '0;
        bus_if.clk_phi = 0;
        bus_if.phi_phase_start_1 = 0;
        bus_if.phi_phase_start_dav = 0;
        bus_if.cycle_num = 0;
        bus_if.badline = 0;
        bus_if.idle = 0; bus_if.bmm = 0; bus_if.ecm = 0;
        bus_if.vc = 0; bus_if.rc = 0;
        bus_if.vm = s_vm; bus_if.cb = s_cb;
        bus_if.dbi = 0;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        rst_n = 1'b1;

        // badline capture and replay of a known pattern
        run_line(1, 99, -1);
        chk("l1_strobes", n_strobe, 40);
        for (int i = 0; i < 40; i++) begin
            chk("l1_char", int'(got_ch[i]), 64 + i);
            chk("l1_color", int'(got_col[i]), i % 16);
        end
        chk("l1_end_vmli", int'(bus_if.vmli), 40);

        // non-badline reuse with different bus data
        s_dbi_mode = 1;
        run_line(0, 99, -1);
        chk("l2_strobes", n_strobe, 40);
        for (int i = 0; i < 40; i++)
            chk("l2_char", int'(got_ch[i]), 64 + i);
        chk("l2_end_vmli", int'(bus_if.vmli), 40);

        // partial badline then replay
        run_line(1, 35, -1);
        run_line(0, 99, -1);
        chk("part_new0", int'(got_ch[0]), int'(rec_dbi[0][7:0]));
        chk("part_new19", int'(got_ch[19]),
            int'(rec_dbi[19][7:0]));
        chk("part_old20", int'(got_ch[20]), 64 + 20);
        chk("part_old39", int'(got_ch[39]), 64 + 39);

        // fill buffer with char ff color a for the mode table
        s_dbi_mode = 2;
        run_line(1, 99, -1);
        s_dbi_mode = 1;
        for (int t = 0; t < 6; t++) begin
            s_idle = tbl[t].idle; s_bmm = tbl[t].bmm;
            s_ecm = tbl[t].ecm; s_cb = tbl[t].cb;
            s_fvc = tbl[t].vc; s_frc = tbl[t].rc;
            s_fixed = 1;
            bus_if.idle = s_idle; bus_if.bmm = s_bmm;
            bus_if.ecm = s_ecm; bus_if.cb = s_cb;
            run_line(0, 99, -1);
            chk("tbl_strobes", n_strobe, 40);
            chk("tbl_g_addr", int'(got_g[0]), int'(tbl[t].exp_g));
            chk("tbl_char", int'(got_ch[0]), int'(tbl[t].exp_ch));
            chk("tbl_color", int'(got_col[0]),
                int'(tbl[t].exp_col));
        end

        // reset mid-line, held to end of line; buffer survives
        s_idle = 0; s_bmm = 0; s_ecm = 0; s_cb = 3'b010;
        s_fixed = 0;
        bus_if.idle = 0; bus_if.bmm = 0; bus_if.ecm = 0;
        bus_if.cb = s_cb;
        run_line(0, 99, 30);
        chk("rst_post_strobes", n_strobe_post_rst, 0);
        run_line(0, 99, -1);
        chk("rst_next_strobes", n_strobe, 40);
        chk("rst_keep_char", int'(got_ch[7]), 'hff);
        chk("rst_keep_color", int'(got_col[33]), 'ha);

        $display("Result: errors=%0d of %0d checks",
                 n_errors, n_checks);
        $finish;
    end
endmodule
